// File: rtl/mult_scheduler.sv
// Round-robin scheduler that time-shares one combinational WIDTHxWIDTH multiplier
// between NUM_REQ requesters using valid/ready request and response handshakes.
module mult_scheduler #(
    parameter int WIDTH   = 6,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic [2*WIDTH-1:0]       mult_out,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_data,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic                     busy,
    output logic [15:0]              ops_done
);
    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [IDXW-1:0]     r_lastGrant;
    logic [IDXW-1:0]     r_grant;
    logic [WIDTH-1:0]    r_opA;
    logic [WIDTH-1:0]    r_opB;
    logic [2*WIDTH-1:0]  r_rspData;
    logic [NUM_REQ-1:0]  r_rspValid;
    logic [15:0]         r_opsDone;

    logic [IDXW-1:0]     w_cand;
    logic [IDXW-1:0]     w_grantIdx;
    logic                w_found;
    logic                w_accept;
    logic                w_rspDone;
    logic [WIDTH-1:0]    w_selA;
    logic [WIDTH-1:0]    w_selB;
    logic [NUM_REQ-1:0]  w_grantHot;
    logic [NUM_REQ-1:0]  w_issuedHot;

    // Search upward from the requester after the last completed one, wrapping at NUM_REQ-1.
    always_comb begin
        w_cand     = r_lastGrant;
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (w_cand == IDXW'(NUM_REQ - 1)) ? '0 : w_cand + IDXW'(1);
            if (!w_found && req_valid[w_cand]) begin
                w_found    = 1'b1;
                w_grantIdx = w_cand;
            end
        end
    end

    always_comb begin
        w_selA      = '0;
        w_selB      = '0;
        w_grantHot  = '0;
        w_issuedHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grantIdx == IDXW'(i)) begin
                w_selA        = req_a[i*WIDTH +: WIDTH];
                w_selB        = req_b[i*WIDTH +: WIDTH];
                w_grantHot[i] = 1'b1;
            end
            if (r_grant == IDXW'(i)) begin
                w_issuedHot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_rspDone   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_found) begin
                    w_accept    = 1'b1;
                    w_nextState = EXEC;
                end
            end
            EXEC: w_nextState = RESP;
            RESP: begin
                if (rsp_ready[r_grant]) begin
                    w_rspDone   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fairness pointer moves only when a response handshake completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastGrant <= IDXW'(NUM_REQ - 1);
            r_grant     <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_rspData   <= '0;
            r_rspValid  <= '0;
            r_opsDone   <= '0;
        end else begin
            if (w_accept) begin
                r_opA   <= w_selA;
                r_opB   <= w_selB;
                r_grant <= w_grantIdx;
            end
            if (r_state == EXEC) begin
                r_rspData  <= mult_out;
                r_rspValid <= w_issuedHot;
            end
            if (w_rspDone) begin
                r_rspValid  <= '0;
                r_lastGrant <= r_grant;
                r_opsDone   <= r_opsDone + 16'd1;
            end
        end
    end

    assign req_ready = (w_accept && !reset) ? w_grantHot : '0;
    assign mult_a    = r_opA;
    assign mult_b    = r_opB;
    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign busy      = (r_state != IDLE);
    assign ops_done  = r_opsDone;

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: directed and randomized operations
// compared against a transaction-level round-robin reference model.
module tb_mult_scheduler;
    localparam int WIDTH   = 6;
    localparam int NUM_REQ = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [3:0]  req_ready;
    logic [5:0]  mult_a;
    logic [5:0]  mult_b;
    logic [11:0] mult_out;
    logic [3:0]  rsp_valid;
    logic [11:0] rsp_data;
    logic [3:0]  rsp_ready;
    logic        busy;
    logic [15:0] ops_done;

    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    logic [5:0]  opA [4];
    logic [5:0]  opB [4];
    int          modelLast;
    logic [15:0] modelOps;
    bit          scrambleAfterAccept;

    mult_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mult_a(mult_a), .mult_b(mult_b), .mult_out(mult_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .ops_done(ops_done)
    );

    // The shared multiplier lives outside the scheduler.
    assign mult_out = {6'd0, mult_a} * {6'd0, mult_b};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] validMask, input logic [3:0] readyMask);
        req_valid = validMask;
        rsp_ready = readyMask;
        req_a     = {opA[3], opA[2], opA[1], opA[0]};
        req_b     = {opB[3], opB[2], opB[1], opB[0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oneHot(input int idx);
        if (idx < 0 || idx > 3) return 4'b0000;
        return 4'b0001 << idx;
    endfunction

    // Reference arbiter: first pending requester after the last served one.
    function automatic int modelGrant(input logic [3:0] mask, input int last);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (last + k) % NUM_REQ;
            if (mask[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic modelReset();
        modelLast = NUM_REQ - 1;
        modelOps  = 16'd0;
    endtask

    task automatic randomizeOperands();
        for (int i = 0; i < NUM_REQ; i++) begin
            opA[i] = 6'($urandom);
            opB[i] = 6'($urandom);
        end
    endtask

    task automatic pulseReset();
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        modelReset();
        tick();
    endtask

    // One full operation: accept cycle, EXEC, RESP with optional stall, then handshake.
    task automatic runOp(input logic [3:0] mask, input int stallCycles, input logic [3:0] strayReady, input bit dropEnable);
        int          g;
        logic [3:0]  gh;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] prod;
        g  = modelGrant(mask, modelLast);
        gh = oneHot(g);
        applyStimulus(mask, 4'b0000);
        #1;
        checkOutput("accept_req_ready", req_ready, gh);
        checkOutput("accept_busy", busy, 1'b0);
        a    = opA[g];
        b    = opB[g];
        prod = 12'(a) * 12'(b);
        tick();
        if (dropEnable) enable = 1'b0;
        if (scrambleAfterAccept) begin
            randomizeOperands();
            applyStimulus(mask, 4'b0000);
        end
        checkOutput("exec_busy", busy, 1'b1);
        checkOutput("exec_mult_a", mult_a, a);
        checkOutput("exec_mult_b", mult_b, b);
        checkOutput("exec_rsp_valid", rsp_valid, 4'b0000);
        #1 checkOutput("exec_req_ready", req_ready, 4'b0000);
        tick();
        checkOutput("resp_rsp_valid", rsp_valid, gh);
        checkOutput("resp_rsp_data", rsp_data, prod);
        for (int s = 0; s < stallCycles; s++) begin
            applyStimulus(req_valid, strayReady & ~gh);
            tick();
            checkOutput("stall_rsp_valid", rsp_valid, gh);
            checkOutput("stall_rsp_data", rsp_data, prod);
            checkOutput("stall_busy", busy, 1'b1);
            #1 checkOutput("stall_req_ready", req_ready, 4'b0000);
        end
        applyStimulus(req_valid, gh | strayReady);
        tick();
        modelLast = g;
        modelOps  = modelOps + 16'd1;
        checkOutput("done_rsp_valid", rsp_valid, 4'b0000);
        checkOutput("done_busy", busy, 1'b0);
        checkOutput("done_ops_done", ops_done, modelOps);
        applyStimulus(4'b0000, 4'b0000);
    endtask

    initial begin
        reset               = 1'b1;
        enable              = 1'b1;
        scrambleAfterAccept = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end
        modelReset();
        applyStimulus(4'b1111, 4'b0000);
        tick();
        tick();
        checkOutput("reset_req_ready", req_ready, 4'b0000);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_mult_a", mult_a, 6'd0);
        checkOutput("reset_mult_b", mult_b, 6'd0);
        checkOutput("reset_rsp_valid", rsp_valid, 4'b0000);
        checkOutput("reset_rsp_data", rsp_data, 12'd0);
        checkOutput("reset_ops_done", ops_done, 16'd0);
        applyStimulus(4'b0000, 4'b0000);
        reset = 1'b0;
        tick();

        $display("[TB] single request from requester 2");
        opA[2] = 6'd63;
        opB[2] = 6'd63;
        runOp(4'b0100, 0, 4'b0000, 1'b0);

        $display("[TB] asynchronous reset mid-cycle");
        #2 reset = 1'b1;
        #1;
        checkOutput("async_mult_a", mult_a, 6'd0);
        checkOutput("async_rsp_data", rsp_data, 12'd0);
        checkOutput("async_rsp_valid", rsp_valid, 4'b0000);
        checkOutput("async_ops_done", ops_done, 16'd0);
        checkOutput("async_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        modelReset();
        tick();

        $display("[TB] round-robin with all requesters valid");
        for (int i = 0; i < NUM_REQ; i++) begin
            opA[i] = 6'(i + 1);
            opB[i] = 6'(i + 2);
        end
        for (int n = 0; n < 5; n++) runOp(4'b1111, 0, 4'b0000, 1'b0);

        $display("[TB] response backpressure on requester 1");
        runOp(4'b0010, 5, 4'b1000, 1'b0);

        $display("[TB] enable dropped during EXEC");
        runOp(4'b1111, 1, 4'b0000, 1'b1);
        applyStimulus(4'b1111, 4'b0000);
        for (int n = 0; n < 3; n++) begin
            #1 checkOutput("gated_req_ready", req_ready, 4'b0000);
            tick();
            checkOutput("gated_busy", busy, 1'b0);
        end
        applyStimulus(4'b0000, 4'b0000);
        enable = 1'b1;
        runOp(4'b1111, 0, 4'b0000, 1'b0);

        $display("[TB] randomized operations");
        scrambleAfterAccept = 1'b1;
        for (int n = 0; n < 30; n++) begin
            randomizeOperands();
            runOp(4'($urandom_range(1, 15)), $urandom_range(0, 3), 4'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                enable = 1'b0;
                applyStimulus(4'($urandom), 4'b0000);
                #1 checkOutput("rand_gated_req_ready", req_ready, 4'b0000);
                tick();
                checkOutput("rand_gated_busy", busy, 1'b0);
                enable = 1'b1;
                applyStimulus(4'b0000, 4'b0000);
            end
        end
        scrambleAfterAccept = 1'b0;

        $display("[TB] reset during RESP");
        pulseReset();
        opA[3] = 6'd5;
        opB[3] = 6'd7;
        applyStimulus(4'b1000, 4'b0000);
        #1 checkOutput("rstresp_req_ready", req_ready, 4'b1000);
        tick();
        applyStimulus(4'b0000, 4'b0000);
        tick();
        checkOutput("rstresp_rsp_valid", rsp_valid, 4'b1000);
        #2 reset = 1'b1;
        applyStimulus(4'b0000, 4'b1111);
        #1;
        checkOutput("rstresp_cleared_valid", rsp_valid, 4'b0000);
        checkOutput("rstresp_cleared_data", rsp_data, 12'd0);
        checkOutput("rstresp_cleared_busy", busy, 1'b0);
        tick();
        tick();
        checkOutput("rstresp_ops_held", ops_done, 16'd0);
        reset = 1'b0;
        modelReset();
        tick();
        checkOutput("rstresp_after_valid", rsp_valid, 4'b0000);
        checkOutput("rstresp_after_ops", ops_done, 16'd0);
        applyStimulus(4'b0000, 4'b0000);

        $display("[TB] ops_done wrap");
        force dut.r_opsDone = 16'hFFFF;
        #1 release dut.r_opsDone;
        modelOps = 16'hFFFF;
        checkOutput("wrap_preload", ops_done, 16'hFFFF);
        randomizeOperands();
        runOp(4'b0010, 1, 4'b0000, 1'b0);
        runOp(4'b0101, 0, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
